// File: rtl/gray_pkg.sv
// Shared types and helpers for the pipelined Gray codec.
package gray_pkg;

  typedef enum logic {
    MODE_G2B = 1'b0,
    MODE_B2G = 1'b1
  } gray_mode_e;

  // Binary bits resolved by each G2B stage (ceil of WIDTH/STAGES).
  function automatic int stage_bits(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int popcount(input logic [31:0] x);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(x[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One elastic register stage of the Gray codec; resolves binary
// bits HI..LO of a G2B word, and does the B2G conversion when FIRST.
module gray_codec_stage
  import gray_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HI    = 7,
  parameter int LO    = 0,
  parameter bit FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_mode,
  input  logic             up_err,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             mode,
  output logic             err
);

  logic [WIDTH-1:0] nxt;
  logic             cin;
  logic             acc;

  // The last resolved bit sits just above this stage's range.
  if (HI >= 0 && HI < WIDTH - 1) begin : g_cin
    assign cin = up_data[HI+1];
  end else begin : g_top
    assign cin = 1'b0;
  end

  always_comb begin
    nxt = up_data;
    acc = cin;
    if (up_mode == MODE_B2G) begin
      if (FIRST) begin
        nxt = up_data ^ (up_data >> 1);
      end
    end else begin
      for (int j = WIDTH - 1; j >= 0; j--) begin
        if (j <= HI && j >= LO) begin
          acc    = acc ^ up_data[j];
          nxt[j] = acc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      mode  <= 1'b0;
      err   <= 1'b0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= nxt;
        mode <= up_mode;
        err  <= up_err;
      end
    end
  end

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray/binary codec with valid/ready stream and
// optional Gray step checker on accepted G2B words.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STAGES   = 2,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_step_err
);

  localparam int K = stage_bits(WIDTH, STAGES);

  logic [STAGES:0]            v;
  logic [STAGES:0]            m;
  logic [STAGES:0]            e;
  logic [STAGES:0][WIDTH-1:0] d;
  logic [STAGES-1:0]          load;
  logic                       step_err;

  assign v[0] = in_valid;
  assign d[0] = in_data;
  assign m[0] = in_mode;
  assign e[0] = step_err;

  assign in_ready     = load[0];
  assign out_valid    = v[STAGES];
  assign out_data     = d[STAGES];
  assign out_mode     = m[STAGES];
  assign out_step_err = e[STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_st
    localparam int HI = WIDTH - 1 - i * K;
    localparam int LO = (WIDTH - (i + 1) * K > 0) ?
                        WIDTH - (i + 1) * K : 0;

    // A stage can load unless it and every stage after it is full
    // and the sink is stalling.
    assign load[i] = out_ready || !(&v[STAGES:i+1]);

    gray_codec_stage #(
      .WIDTH(WIDTH),
      .HI   (HI),
      .LO   (LO),
      .FIRST(i == 0)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .load    (load[i]),
      .up_valid(v[i]),
      .up_data (d[i]),
      .up_mode (m[i]),
      .up_err  (e[i]),
      .valid   (v[i+1]),
      .data    (d[i+1]),
      .mode    (m[i+1]),
      .err     (e[i+1])
    );
  end

  if (CHECK_EN) begin : g_chk
    logic [WIDTH-1:0] hist;
    logic             hist_vld;
    logic             g2b;

    assign g2b      = (in_mode == MODE_G2B);
    assign step_err = g2b && hist_vld &&
                      (popcount(32'(in_data ^ hist)) > 1);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hist     <= '0;
        hist_vld <= 1'b0;
      end else if (in_valid && in_ready && g2b) begin
        hist     <= in_data;
        hist_vld <= 1'b1;
      end
    end
  end else begin : g_nochk
    assign step_err = 1'b0;
  end

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Randomised self-checking bench for gray_codec_pipe against a
// prefix-XOR / queue reference model.
module tb_gray_codec_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, in_mode;
  logic       out_valid, out_ready, out_mode, out_step_err;
  logic [7:0] in_data, out_data;

  logic       a_in_valid, a_in_ready, a_in_mode;
  logic       a_out_valid, a_out_ready, a_out_mode, a_out_err;
  logic [3:0] a_in_data, a_out_data;

  logic       b_in_valid, b_in_ready, b_in_mode;
  logic       b_out_valid, b_out_ready, b_out_mode, b_out_err;
  logic [4:0] b_in_data, b_out_data;

  logic       c_in_valid, c_in_ready, c_in_mode;
  logic       c_out_valid, c_out_ready, c_out_mode, c_out_err;
  logic [4:0] c_in_data, c_out_data;

  gray_codec_pipe #(.WIDTH(8), .STAGES(3), .CHECK_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode),
    .out_step_err(out_step_err)
  );

  gray_codec_pipe #(.WIDTH(4), .STAGES(2), .CHECK_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_mode(a_out_mode),
    .out_step_err(a_out_err)
  );

  gray_codec_pipe #(.WIDTH(5), .STAGES(5), .CHECK_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_mode(b_out_mode),
    .out_step_err(b_out_err)
  );

  gray_codec_pipe #(.WIDTH(5), .STAGES(1), .CHECK_EN(1'b0)) dut_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_mode(c_in_mode),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_mode(c_out_mode),
    .out_step_err(c_out_err)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] hist_m;
  logic       hvld_m;
  logic [9:0] exp_q[$];

  // Binary value of a Gray word: XOR of all right shifts.
  function automatic logic [7:0] g2b_ref(input logic [7:0] g);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic model_push(input logic [7:0] x, input logic md);
    logic       er;
    logic [7:0] r;
    er = 1'b0;
    if (md == 1'b0) begin
      er     = hvld_m && ($countones(x ^ hist_m) > 1);
      hist_m = x;
      hvld_m = 1'b1;
      r      = g2b_ref(x);
    end else begin
      r = x ^ (x >> 1);
    end
    exp_q.push_back({er, md, r});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hvld_m = 1'b0;
    hist_m = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, out_data, out_mode, out_step_err} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h m=%b e=%b required all 0",
               out_valid, out_data, out_mode, out_step_err);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_small();
    logic [3:0] din [2];
    logic [3:0] dout[2];
    int         lat;
    din[0] = 4'b1011; dout[0] = 4'b1101;
    din[1] = 4'b1101; dout[1] = 4'b1011;
    do_reset();
    a_out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data  = din[t];
      a_in_mode  = 1'(t);
      lat = 0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        if (a_out_valid && lat == 0) begin
          lat = c;
          n_tests++;
          if (a_out_data !== dout[t] || a_out_mode !== 1'(t)) begin
            n_fail++;
            $display("FAIL small_data%0d got %b/%b required %b/%b",
                     t, a_out_data, a_out_mode, dout[t], 1'(t));
          end
        end
      end
      n_tests++;
      if (lat != 2) begin
        n_fail++;
        $display("FAIL small_latency%0d got %0d required 2", t, lat);
      end
    end
  endtask

  task automatic test_throughput();
    int sent, got, cyc;
    do_reset();
    out_ready = 1'b1;
    sent = 0; got = 0; cyc = 0;
    while (got < 256 && cyc < 300) begin
      @(negedge clk);
      if (sent < 256) begin
        in_valid = 1'b1;
        in_data  = 8'(sent ^ (sent >> 1));
        in_mode  = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid) begin
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL thru_in_ready cycle %0d got %b required 1",
                   cyc, in_ready);
        end
      end
      if (out_valid) begin
        n_tests++;
        if (out_data !== 8'(got) || out_step_err !== 1'b0) begin
          n_fail++;
          $display("FAIL thru_data got %h err %b required %h err 0",
                   out_data, out_step_err, 8'(got));
        end
        if (got == 0) begin
          n_tests++;
          if (cyc != 3) begin
            n_fail++;
            $display("FAIL thru_latency got %0d required 3", cyc);
          end
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 256) begin
      n_fail++;
      $display("FAIL thru_count got %0d required 256", got);
    end
  endtask

  task automatic test_backpressure();
    int         sent, cyc;
    logic       pending, saw_full, held_v;
    logic [9:0] held, ex;
    do_reset();
    sent = 0; cyc = 0;
    pending = 0; saw_full = 0; held_v = 0; held = '0;
    while ((sent < 10 || exp_q.size() > 0) && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 8);
      if (sent < 10) begin
        in_valid = 1'b1;
        if (!pending) begin
          in_data = 8'($urandom);
          in_mode = 1'($urandom);
          pending = 1'b1;
        end
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_tests++;
      if (in_ready !== ((exp_q.size() < 3) || out_ready)) begin
        n_fail++;
        $display("FAIL bp_in_ready cycle %0d got %b occupancy %0d",
                 cyc, in_ready, exp_q.size());
      end
      if (!in_ready) saw_full = 1'b1;
      if (held_v) begin
        n_tests++;
        if (!out_valid ||
            {out_step_err, out_mode, out_data} !== held) begin
          n_fail++;
          $display("FAIL bp_stable got v=%b %h required v=1 %h",
                   out_valid, {out_step_err, out_mode, out_data}, held);
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out_step_err, out_mode, out_data};
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra got %h required no word", held);
        end else begin
          ex = exp_q.pop_front();
          if (held !== ex) begin
            n_fail++;
            $display("FAIL bp_word got %h required %h", held, ex);
          end
        end
      end
      if (in_valid && in_ready) begin
        model_push(in_data, in_mode);
        sent++;
        pending = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (!saw_full || sent != 10 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_done got full=%b sent=%0d left=%0d required 1/10/0",
               saw_full, sent, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [9:0] got, ex;
    int         drain;
    do_reset();
    drain = 0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      @(negedge clk);
      if (cyc < 400) begin
        if (!(in_valid && !in_ready)) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = 8'($urandom);
          in_mode  = 1'($urandom);
          if ($urandom_range(0, 1) == 1)
            in_data = hist_m ^ (8'd1 << $urandom_range(0, 7));
        end
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain++;
      end
      #1;
      n_tests++;
      if (in_ready !== ((exp_q.size() < 3) || out_ready)) begin
        n_fail++;
        $display("FAIL rnd_in_ready cycle %0d got %b occupancy %0d",
                 cyc, in_ready, exp_q.size());
      end
      got = {out_step_err, out_mode, out_data};
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra got %h required no word", got);
        end else begin
          ex = exp_q.pop_front();
          if (got !== ex) begin
            n_fail++;
            $display("FAIL rnd_word got %h required %h", got, ex);
          end
        end
      end
      if (in_valid && in_ready) model_push(in_data, in_mode);
    end
    n_tests++;
    if (exp_q.size() != 0 || drain == 0) begin
      n_fail++;
      $display("FAIL rnd_drain got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_step_err();
    logic [7:0] wd[5];
    logic       md[5];
    logic       er[5];
    logic [9:0] got, ex;
    int         sent, k;
    wd = '{8'h00, 8'h01, 8'hA5, 8'h03, 8'h00};
    md = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    out_ready = 1'b1;
    sent = 0; k = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      in_valid = (sent < 5);
      if (sent < 5) begin
        in_data = wd[sent];
        in_mode = md[sent];
      end
      #1;
      if (in_valid) begin
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL step_no_stall word %0d got %b required 1",
                   sent, in_ready);
        end
      end
      got = {out_step_err, out_mode, out_data};
      if (out_valid && k < 5) begin
        n_tests++;
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
        if (got !== ex || out_step_err !== er[k]) begin
          n_fail++;
          $display("FAIL step_word%0d got %h required %h err %b",
                   k, got, ex, er[k]);
        end
        k++;
      end
      if (in_valid && in_ready) begin
        model_push(in_data, in_mode);
        sent++;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (k != 5) begin
      n_fail++;
      $display("FAIL step_count got %0d required 5", k);
    end
  endtask

  task automatic test_reset_mid();
    int sent, lat;
    do_reset();
    sent = 0;
    while (sent < 3) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h0F + 8'(sent);
      in_mode  = 1'b0;
      #1;
      if (in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_full got out_valid %b required 1", out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async got out_valid %b required 0", out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_stale cycle %0d got out_valid 1 required 0", c);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_mode  = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid && lat == 0) begin
        lat = c;
        n_tests++;
        if (out_data !== 8'hAA || out_step_err !== 1'b0) begin
          n_fail++;
          $display("FAIL mid_first got %h err %b required aa err 0",
                   out_data, out_step_err);
        end
      end
    end
    n_tests++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL mid_latency got %0d required 3", lat);
    end
  endtask

  task automatic test_corners();
    int lat_b, lat_c;
    do_reset();
    b_out_ready = 1'b1;
    c_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = 5'b11111; b_in_mode = 1'b0;
    c_in_valid = 1'b1; c_in_data = 5'b11111; c_in_mode = 1'b0;
    lat_b = 0; lat_c = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      c_in_valid = 1'b0;
      #1;
      if (b_out_valid && lat_b == 0) begin
        lat_b = c;
        n_tests++;
        if (b_out_data !== 5'b10101) begin
          n_fail++;
          $display("FAIL corner5_data got %b required 10101", b_out_data);
        end
      end
      if (c_out_valid && lat_c == 0) begin
        lat_c = c;
        n_tests++;
        if (c_out_data !== 5'b10101) begin
          n_fail++;
          $display("FAIL corner1_data got %b required 10101", c_out_data);
        end
      end
    end
    n_tests++;
    if (lat_b != 5 || lat_c != 1) begin
      n_fail++;
      $display("FAIL corner_latency got %0d/%0d required 5/1",
               lat_b, lat_c);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 1'b0;
    a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 1'b0;
    b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = '0; c_in_mode = 1'b0;
    c_out_ready = 1'b0;
    hist_m = '0;
    hvld_m = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_small();
    test_throughput();
    test_backpressure();
    test_step_err();
    test_random();
    test_reset_mid();
    test_corners();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
Parametrised, pipelined Gray-code codec with a valid/ready stream interface.
- Each transaction carries its own mode: Gray-to-binary (prefix-XOR) or binary-to-Gray.
- Latency is fixed at STAGES cycles.
- An optional step checker flags Gray inputs that change more than one bit between consecutive accepted samples, for encoder and CDC monitoring.
- Sits between CDC synchronisers or position encoders and downstream binary arithmetic.

Parameters:
WIDTH, 8, data width in bits; legal range 2..32.
STAGES, 2, pipeline register stages; legal range 1..WIDTH.
CHECK_EN, 1, 1 = instantiate the Gray step checker; 0 = out_step_err tied to 0.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  input word present
in_ready  output  1  block can accept the input word this cycle
in_data  input  WIDTH  input word, Gray or binary according to in_mode
in_mode  input  1  0 = Gray-to-binary (G2B), 1 = binary-to-Gray (B2G)
out_valid  output  1  result present
out_ready  input  1  downstream accepts the result
out_data  output  WIDTH  converted word
out_mode  output  1  mode that travelled with the word
out_step_err  output  1  step error flag that travelled with the word

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All stage valid bits = 0.
  - out_valid = 0, out_data = 0, out_mode = 0, out_step_err = 0.
  - Checker history cleared; hist_vld = 0.
  - A reset mid-transfer discards all in-flight words. No output appears for them.
- Accept and release:
  - Input accepted when in_valid && in_ready.
  - Output released when out_valid && out_ready.
  - in_data and in_mode must be held while in_valid && !in_ready.
  - out_data, out_mode and out_step_err are held stable while out_valid && !out_ready.
- Elastic pipeline, stages 0..STAGES-1:
  - adv[i] = v[i] && (i == STAGES-1 ? out_ready : load_ok[i+1])
  - load_ok[i] = !v[i] || adv[i]
  - in_ready = load_ok[0]
- Throughput and latency:
  - Full throughput of one word per cycle, no bubbles.
  - Combinational path out_ready -> in_ready is permitted.
  - Latency is STAGES cycles from accept to out_valid when out_ready stays high.
  - Word order is preserved.
- G2B partition:
  - K = ceil(WIDTH/STAGES).
  - Stage s (0-based) resolves binary bits [WIDTH-1-s*K] down to max(WIDTH-(s+1)*K, 0).
  - Rule: bin[MSB] = g[MSB]; bin[j] = bin[j+1] ^ g[j].
  - Each stage carries the remaining unresolved Gray bits plus the last resolved bit.
  - Stages with no bits left pass data through unchanged.
- B2G: gray = bin ^ (bin >> 1), computed in stage 0. Later stages pass it through.
- Mode: sampled at accept and carried per word. Mixing modes back-to-back is legal with no stall.
- Step checker (CHECK_EN = 1):
  - Evaluated at accept of a G2B word only.
  - err = hist_vld && (popcount(in_data ^ hist) > 1).
  - Then hist <= in_data and hist_vld <= 1.
  - B2G words never update hist and carry err = 0.
  - The first G2B word after reset never flags.
  - Identical consecutive Gray words (distance 0) do not flag.
  - err travels with the word and appears on out_step_err together with that word's out_valid.
- Simultaneous accept and release in one cycle: both take effect, and occupancy is unchanged.

Decomposition:
- Package gray_pkg contains:
  - typedef enum logic {MODE_G2B = 1'b0, MODE_B2G = 1'b1} gray_mode_e
  - constant function stage_bits(WIDTH, STAGES), returning K
  - function popcount
- Sub-module gray_codec_stage: one register stage holding valid, data, mode, err and the carried bit, parametrised by its resolved bit range.
- Top-level generate instantiates STAGES copies, plus the checker in the top level.

Test Plan:
- Reset, WIDTH=4, STAGES=2:
  - G2B in_data=4'b1011 -> out_data=4'b1101 after exactly 2 cycles.
  - Then B2G in_data=4'b1101 -> out_data=4'b1011, out_mode=1.
- Full throughput, WIDTH=8, out_ready=1:
  - Stream G2B Gray 0x00..0xFF.
  - -> Binary 0x00..0xFF appears in order, one per cycle.
  - -> in_ready stays 1 and out_step_err stays 0.
- Backpressure:
  - Drop out_ready for 5 cycles during a 10-word burst.
  - -> in_ready falls once STAGES words are held.
  - -> out_data is stable while stalled; no loss or duplication; order preserved.
- Step error:
  - G2B sequence 0000, 0001, 0011, 0000.
  - -> out_step_err = 0, 0, 0, 1 (distance 2 on the last word).
  - An interleaved B2G word between them does not disturb hist.
- Reset mid-operation:
  - Assert rst with STAGES words in flight.
  - -> out_valid = 0 immediately; no stale word after release.
  - -> The next G2B word does not flag.
- Corners:
  - WIDTH=5, STAGES=5 and STAGES=1: G2B 5'b11111 -> 5'b10101.
  - Latency is 5 and 1 cycles respectively.
